gpio_bank: RTL and testbench



---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_debounce.sv | 56 +++++
 rtl/gpio_bank.sv | 119 +++++++++++
 tb/tb_gpio_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: defaults, prime state encoding and
// the pad tristate reset level.
package gpio_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Bank-wide start-up sequencing: PRIME loads the filters straight from the
    // synchronisers, RUN applies debounce and edge detection.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } prime_state_t;

    // Pads float until the PS has driven the tristate vector at least once.
    localparam logic PAD_T_RESET = 1'b1;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: metastability synchroniser followed by a
// programmable debounce filter with a prime bypass for start-up.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pad,
    input  logic                  prime,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    output logic                  sync,
    output logic                  filt
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic [DEBOUNCE_W-1:0]  cnt;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [DEBOUNCE_W-1:0] sat_inc(input logic [DEBOUNCE_W-1:0] v);
        return (&v) ? v : v + DEBOUNCE_W'(1);
    endfunction

    // Shift the asynchronous pad through the synchroniser flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    // Accept a new level only after it has differed from filt for
    // debounce_len+1 consecutive cycles; any return to filt restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (prime) begin
            filt <= sync;
            cnt  <= '0;
        end else if (sync == filt) begin
            cnt <= '0;
        end else if (cnt >= debounce_len) begin
            filt <= sync;
            cnt  <= '0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank between the PS GPIO port and the board IO buffers: registered
// output/tristate path, debounced inputs, edge-triggered sticky status and a
// single level interrupt. Channels without a pad are looped back in fabric.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int               WIDTH         = 64,
    parameter int               SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int               DEBOUNCE_W    = 8,
    parameter logic [WIDTH-1:0] LOOPBACK_MASK = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      gpio_o,
    input  logic [WIDTH-1:0]      gpio_t,
    output logic [WIDTH-1:0]      gpio_i,
    input  logic [WIDTH-1:0]      pad_i,
    output logic [WIDTH-1:0]      pad_o,
    output logic [WIDTH-1:0]      pad_t,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    input  logic [WIDTH-1:0]      rise_en,
    input  logic [WIDTH-1:0]      fall_en,
    input  logic [WIDTH-1:0]      irq_en,
    input  logic [WIDTH-1:0]      irq_clear,
    output logic [WIDTH-1:0]      irq_status,
    output logic                  irq
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 1) + 1;

    prime_state_t       state;
    logic [PRIME_W-1:0] prime_cnt;
    logic               prime;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] ev;

    assign prime = (state == PRIME);

    // Stay in PRIME for SYNC_STAGES+1 cycles so the synchronisers fill with
    // the real pad levels before edge detection is trusted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            case (state)
                PRIME: begin
                    if (prime_cnt == PRIME_W'(SYNC_STAGES)) begin
                        state <= RUN;
                    end else begin
                        prime_cnt <= prime_cnt + PRIME_W'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_debounce (
            .clk          (clk),
            .rst          (rst),
            .pad          (pad_i[i]),
            .prime        (prime),
            .debounce_len (debounce_len),
            .sync         (sync[i]),
            .filt         (filt[i])
        );
    end

    // Register the PS drive towards the IO buffers; loopback bits never drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_o <= '0;
            pad_t <= {WIDTH{PAD_T_RESET}};
        end else begin
            pad_o <= gpio_o;
            pad_t <= gpio_t | LOOPBACK_MASK;
        end
    end

    // Delayed filter for edge detection; during PRIME it tracks the value the
    // filter is loading so the PRIME->RUN handover sees no false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            filt_q <= prime ? sync : filt;
        end
    end

    assign ev = prime ? '0 :
                (((filt & ~filt_q & rise_en) | (~filt & filt_q & fall_en)) & ~LOOPBACK_MASK);

    // Sticky status: clear first, then OR in new events so an event wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | ev;
            irq        <= |(irq_status & irq_en);
        end
    end

    assign gpio_i = (gpio_o & LOOPBACK_MASK) | (filt & ~LOOPBACK_MASK);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with channel 47 configured as loopback.
module tb_gpio_bank;

    localparam int          WIDTH = 64;
    localparam logic [63:0] MASK  = 64'h0000_8000_0000_0000;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  gpio_o;
    logic [WIDTH-1:0]  gpio_t;
    logic [WIDTH-1:0]  gpio_i;
    logic [WIDTH-1:0]  pad_i;
    logic [WIDTH-1:0]  pad_o;
    logic [WIDTH-1:0]  pad_t;
    logic [7:0]        debounce_len;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  irq_en;
    logic [WIDTH-1:0]  irq_clear;
    logic [WIDTH-1:0]  irq_status;
    logic              irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (2),
        .DEBOUNCE_W    (8),
        .LOOPBACK_MASK (MASK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_o       (gpio_o),
        .gpio_t       (gpio_t),
        .gpio_i       (gpio_i),
        .pad_i        (pad_i),
        .pad_o        (pad_o),
        .pad_t        (pad_t),
        .debounce_len (debounce_len),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .irq_en       (irq_en),
        .irq_clear    (irq_clear),
        .irq_status   (irq_status),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        gpio_o       = '0;
        gpio_t       = '0;
        pad_i        = 64'h8;
        debounce_len = 8'd0;
        rise_en      = '1;
        fall_en      = '0;
        irq_en       = '0;
        irq_clear    = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pad_o", pad_o, 64'h0);
        chk("rst_pad_t", pad_t, {64{1'b1}});
        chk("rst_gpio_i", gpio_i, 64'h0);
        chk("rst_status", irq_status, 64'h0);
        chk("rst_irq", {63'b0, irq}, 64'h0);
        gpio_o = 64'hA5;
        @(negedge clk);
        chk("rst_hold_pad_o", pad_o, 64'h0);

        // Release with pad_i[3] held high: primed after 3 cycles, no event
        rst = 1'b0;
        @(negedge clk);
        chk("out_pad_o", pad_o, 64'hA5);
        chk("out_pad_t", pad_t, MASK);
        chk("prime_c1", gpio_i, 64'h0);
        @(negedge clk);
        chk("prime_c2", gpio_i, 64'h0);
        @(negedge clk);
        chk("prime_c3", gpio_i, 64'h8);
        repeat (3) @(negedge clk);
        chk("prime_no_status", irq_status, 64'h0);
        chk("prime_no_irq", {63'b0, irq}, 64'h0);

        // Debounce: 4-cycle glitch rejected with debounce_len = 4
        rise_en      = 64'h20;
        debounce_len = 8'd4;
        pad_i[0]     = 1'b1;
        repeat (4) @(negedge clk);
        pad_i[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("glitch_reject", {63'b0, gpio_i[0]}, 64'h0);
        end

        // Held level accepted 7 cycles after the pad edge
        pad_i[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("db_c6", {63'b0, gpio_i[0]}, 64'h0);
        @(negedge clk);
        chk("db_c7", {63'b0, gpio_i[0]}, 64'h1);

        // Rising edge on bit 5 -> status, irq, then clear
        debounce_len = 8'd0;
        irq_en       = 64'h20;
        pad_i[5]     = 1'b1;
        repeat (2) @(negedge clk);
        chk("b5_c2", {63'b0, gpio_i[5]}, 64'h0);
        @(negedge clk);
        chk("b5_c3", {63'b0, gpio_i[5]}, 64'h1);
        chk("b5_status_pre", irq_status, 64'h0);
        @(negedge clk);
        chk("b5_status_set", irq_status, 64'h20);
        chk("b5_irq_pre", {63'b0, irq}, 64'h0);
        @(negedge clk);
        chk("b5_irq_set", {63'b0, irq}, 64'h1);
        irq_clear = 64'h20;
        @(negedge clk);
        irq_clear = '0;
        chk("b5_status_clr", irq_status, 64'h0);
        chk("b5_irq_lag", {63'b0, irq}, 64'h1);
        @(negedge clk);
        chk("b5_irq_clr", {63'b0, irq}, 64'h0);

        // Clear coincident with a new event: event wins
        pad_i[5] = 1'b0;
        repeat (5) @(negedge clk);
        chk("b5_fall_noev", irq_status, 64'h0);
        pad_i[5] = 1'b1;
        repeat (3) @(negedge clk);
        irq_clear = 64'h20;
        @(negedge clk);
        irq_clear = '0;
        chk("clr_vs_event", irq_status, 64'h20);
        @(negedge clk);
        chk("clr_vs_event_irq", {63'b0, irq}, 64'h1);

        // Loopback channel 47
        rise_en = '1;
        fall_en = '1;
        gpio_o[47] = 1'b1;
        #1;
        chk("lb_gpio_i_hi", {63'b0, gpio_i[47]}, 64'h1);
        @(negedge clk);
        chk("lb_pad_o", {63'b0, pad_o[47]}, 64'h1);
        chk("lb_pad_t", pad_t, MASK);
        gpio_o[47] = 1'b0;
        #1;
        chk("lb_gpio_i_lo", {63'b0, gpio_i[47]}, 64'h0);
        gpio_t = 64'hF0;
        @(negedge clk);
        chk("out_gpio_t", pad_t, 64'hF0 | MASK);
        repeat (2) @(negedge clk);
        chk("lb_no_event", irq_status, 64'h20);

        // Reset mid-debounce while irq is asserted, then PRIME again
        debounce_len = 8'd4;
        pad_i[9]     = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_irq", {63'b0, irq}, 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pad_o", pad_o, 64'h0);
        chk("mid_rst_pad_t", pad_t, {64{1'b1}});
        chk("mid_rst_status", irq_status, 64'h0);
        chk("mid_rst_irq", {63'b0, irq}, 64'h0);
        chk("mid_rst_gpio_i", gpio_i, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reprime_c2", gpio_i, 64'h0);
        @(negedge clk);
        chk("reprime_c3", gpio_i, 64'h229);
        repeat (3) @(negedge clk);
        chk("reprime_no_status", irq_status, 64'h0);
        chk("reprime_no_irq", {63'b0, irq}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
